// File: rtl/mult_job_sequencer.sv
// Operand-pair queue feeding a multi-cycle external multiplier; returns products in push order.
// Optional build macro MULT_SEQ_ZERO_BYPASS_EN: pairs with a zero operand skip the multiplier.
module mult_job_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int LOAD_CYCLES = 2,
   parameter int MUL_LATENCY = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        mul_rst,
   output logic [31:0] mul_in1,
   output logic [31:0] mul_in2,
   input  logic [63:0] mul_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        busy
);

   localparam int AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_MAX = (LOAD_CYCLES > MUL_LATENCY) ? LOAD_CYCLES : MUL_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
   localparam logic [CW-1:0] RUN_LAST  = CW'(MUL_LATENCY - 1);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_s;
   logic            byp_r;
   logic            byp_s;
   logic [63:0]     mem_r [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_r;
   logic [AW:0]     rd_ptr_r;
   logic [AW:0]     wr_ptr_s;
   logic [AW:0]     rd_ptr_s;
   logic            empty_s;
   logic            push_s;
   logic            pop_s;
   logic            capture_s;
   logic            byp_done_s;
   logic            release_s;
   logic [63:0]     head_s;

   // Full when the low pointer bits match but the wrap bits differ.
   function automatic logic ptr_full(input logic [AW:0] wr, input logic [AW:0] rd);
      return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
   endfunction

`ifdef MULT_SEQ_ZERO_BYPASS_EN
   function automatic logic is_zero_pair(input logic [63:0] pair);
      return (pair[63:32] == 32'd0) || (pair[31:0] == 32'd0);
   endfunction
`endif

   // Queue status, handshakes and FSM next-state.
   always_comb begin
      push_s     = op_valid && op_ready;
      empty_s    = (wr_ptr_r == rd_ptr_r);
      head_s     = mem_r[rd_ptr_r[AW-1:0]];
      pop_s      = 1'b0;
      capture_s  = 1'b0;
      byp_done_s = 1'b0;
      release_s  = 1'b0;
      state_s    = state_r;
      cnt_s      = cnt_r;
      byp_s      = byp_r;
      case (state_r)
         IDLE: begin
            if (byp_r) begin
               // a zero pair popped last cycle completes without the multiplier
               state_s    = DONE;
               byp_s      = 1'b0;
               byp_done_s = 1'b1;
            end else if (!empty_s) begin
               pop_s = 1'b1;
               cnt_s = {CW{1'b0}};
`ifdef MULT_SEQ_ZERO_BYPASS_EN
               if (is_zero_pair(head_s)) begin
                  byp_s   = 1'b1;
                  state_s = IDLE;
               end else begin
                  byp_s   = 1'b0;
                  state_s = LOAD;
               end
`else
               byp_s   = 1'b0;
               state_s = LOAD;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (cnt_r == LOAD_LAST) begin
               state_s = RUN;
               cnt_s   = {CW{1'b0}};
            end else begin
               state_s = LOAD;
               cnt_s   = cnt_r + CW'(1);
            end
         end
         RUN: begin
            if (cnt_r == RUN_LAST) begin
               state_s   = DONE;
               cnt_s     = {CW{1'b0}};
               capture_s = 1'b1;
            end else begin
               state_s = RUN;
               cnt_s   = cnt_r + CW'(1);
            end
         end
         DONE: begin
            if (res_valid && res_ready) begin
               state_s   = IDLE;
               release_s = 1'b1;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
            byp_s   = 1'b0;
         end
      endcase
      if (push_s) begin
         wr_ptr_s = wr_ptr_r + (AW + 1)'(1);
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_s = rd_ptr_r + (AW + 1)'(1);
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
   end

   // FSM state, service counter and operand queue storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         byp_r    <= 1'b0;
         wr_ptr_r <= {(AW + 1){1'b0}};
         rd_ptr_r <= {(AW + 1){1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 64'd0;
         end
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         byp_r    <= byp_s;
         wr_ptr_r <= wr_ptr_s;
         rd_ptr_r <= rd_ptr_s;
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {op_a, op_b};
         end
      end
   end

   // Registered status and multiplier-side outputs; mul_rst is high while held in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_ready <= 1'b0;
         mul_rst  <= 1'b1;
         busy     <= 1'b0;
         mul_in1  <= 32'd0;
         mul_in2  <= 32'd0;
      end else begin
         op_ready <= !ptr_full(wr_ptr_s, rd_ptr_s);
         mul_rst  <= (state_s == LOAD);
         busy     <= (state_s != IDLE) || (wr_ptr_s != rd_ptr_s) || byp_s;
         if (pop_s) begin
            mul_in1 <= head_s[63:32];
            mul_in2 <= head_s[31:0];
         end
      end
   end

   // Result register: captured once per job and held until the downstream handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_data  <= 64'd0;
      end else if (capture_s) begin
         res_valid <= 1'b1;
         res_data  <= mul_out;
      end else if (byp_done_s) begin
         res_valid <= 1'b1;
         res_data  <= 64'd0;
      end else if (release_s) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Scoreboard bench for mult_job_sequencer with a behavioural fixed-latency multiplier.
module tb_mult_job_sequencer;

   localparam int LOAD_C  = 2;
   localparam int MUL_LAT = 33;
   localparam int FULL_LAT = 1 + LOAD_C + MUL_LAT;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        mul_rst;
   logic [31:0] mul_in1;
   logic [31:0] mul_in2;
   logic [63:0] mul_out;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic        busy;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          res_seen = 0;
   int          mcnt = 0;
   logic [63:0] exp_q [$];
   logic [63:0] mon_exp;
   logic signed [63:0] a64;
   logic signed [63:0] b64;

   mult_job_sequencer #(
      .FIFO_DEPTH (4),
      .LOAD_CYCLES(LOAD_C),
      .MUL_LATENCY(MUL_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_a     (op_a),
      .op_b     (op_b),
      .mul_rst  (mul_rst),
      .mul_in1  (mul_in1),
      .mul_in2  (mul_in2),
      .mul_out  (mul_out),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model: product is only trustworthy MUL_LAT edges after mul_rst falls.
   always @(posedge clk or negedge rst) begin
      if (!rst) mcnt <= 0;
      else if (mul_rst) mcnt <= 0;
      else if (mcnt < MUL_LAT) mcnt <= mcnt + 1;
   end
   assign a64 = {{32{mul_in1[31]}}, mul_in1};
   assign b64 = {{32{mul_in2[31]}}, mul_in2};
   assign mul_out = (mcnt >= MUL_LAT - 1) ? 64'(a64 * b64) : 64'hBAD0_BAD0_BAD0_BAD0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
   endtask

   // Monitor: every accepted result is compared with the oldest expected product.
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         res_seen++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_result: got 0x%016h expected no result", res_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("result", res_data, mon_exp);
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                       input bit track, output int t);
      bit ok;
      ok = 1'b0;
      op_a = a;
      op_b = b;
      op_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (op_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      op_valid = 1'b0;
      t = cyc;
      chk("push_accept", {63'd0, ok}, 64'd1);
      if (ok && track) exp_q.push_back(exp);
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                             input int exp_lat, input int exp_pulses);
      int t;
      int pulses;
      bit seen;
      pulses = 0;
      seen = 1'b0;
      push(a, b, exp, 1'b1, t);
      for (int i = 0; i < 100; i++) begin
         if (res_valid) begin
            seen = 1'b1;
            break;
         end
         if (mul_rst) pulses++;
         @(negedge clk);
      end
      chk("result_seen", {63'd0, seen}, 64'd1);
      chk("latency", 64'(cyc - t), 64'(exp_lat));
      chk("mul_rst_pulse_cycles", 64'(pulses), 64'(exp_pulses));
      chk("mul_in1_stable", {32'd0, mul_in1}, {32'd0, a});
      chk("mul_in2_stable", {32'd0, mul_in2}, {32'd0, b});
      @(negedge clk);
      chk("busy_after_job", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int t;
      int seen_before;
      bit seen;
      rst = 1'b1;
      op_valid = 1'b0;
      op_a = 32'd0;
      op_b = 32'd0;
      res_ready = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_op_ready", {63'd0, op_ready}, 64'd0);
      chk("rst_mul_rst", {63'd0, mul_rst}, 64'd1);
      chk("rst_mul_in1", {32'd0, mul_in1}, 64'd0);
      chk("rst_mul_in2", {32'd0, mul_in2}, 64'd0);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_res_data", res_data, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("op_ready_after_rst", {63'd0, op_ready}, 64'd1);
      chk("mul_rst_after_rst", {63'd0, mul_rst}, 64'd0);

      // single job latency: 2*5
      res_ready = 1'b1;
      run_single(32'd2, 32'd5, 64'd10, FULL_LAT, LOAD_C);

      // back-to-back signed pairs
      push(32'd2, -32'sd5, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1, t);
      push(-32'sd132, -32'sd5, 64'd660, 1'b1, t);
      push(-32'sd132, 32'd5, 64'hFFFF_FFFF_FFFF_FD6C, 1'b1, t);
      drain(3 * 45);

      // back-pressure: queue of 4 plus one in service
      res_ready = 1'b0;
      push(32'd3, 32'd7, 64'd21, 1'b1, t);
      push(-32'sd4, 32'd6, 64'hFFFF_FFFF_FFFF_FFE8, 1'b1, t);
      push(32'd100000, 32'd100000, 64'd10000000000, 1'b1, t);
      push(-32'sd1, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, t);
      push(32'd65536, -32'sd65536, 64'hFFFF_FFFF_0000_0000, 1'b1, t);
      chk("op_ready_full", {63'd0, op_ready}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (res_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("held_result_seen", {63'd0, seen}, 64'd1);
      repeat (5) @(negedge clk);
      chk("held_res_valid", {63'd0, res_valid}, 64'd1);
      chk("held_res_data", res_data, 64'd21);
      chk("held_op_ready", {63'd0, op_ready}, 64'd0);
      res_ready = 1'b1;
      drain(5 * 45);

      // extreme operands
      push(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'd4611686014132420609, 1'b1, t);
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b1, t);
      drain(2 * 45);

      // reset during RUN with two pairs queued
      push(32'd7, 32'd9, 64'd63, 1'b0, t);
      push(32'd8, 32'd8, 64'd64, 1'b0, t);
      push(32'd6, 32'd6, 64'd36, 1'b0, t);
      repeat (8) @(negedge clk);
      chk("busy_in_run", {63'd0, busy}, 64'd1);
      rst = 1'b0;
      #1;
      chk("abort_op_ready", {63'd0, op_ready}, 64'd0);
      chk("abort_mul_rst", {63'd0, mul_rst}, 64'd1);
      chk("abort_mul_in1", {32'd0, mul_in1}, 64'd0);
      chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
      chk("abort_res_data", res_data, 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen_before = res_seen;
      repeat (3 * 40) @(negedge clk);
      chk("no_result_after_abort", 64'(res_seen - seen_before), 64'd0);
      chk("idle_after_abort", {63'd0, busy}, 64'd0);
      run_single(32'd5, 32'd1, 64'd5, FULL_LAT, LOAD_C);

      // zero operand
`ifdef MULT_SEQ_ZERO_BYPASS_EN
      run_single(32'd5, 32'd0, 64'd0, 2, 0);
`else
      run_single(32'd5, 32'd0, 64'd0, FULL_LAT, LOAD_C);
`endif
      drain(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mult_job_sequencer.md
MULT_JOB_SEQUENCER -- requirements
Module: mult_job_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the operand-pair queue depth; it SHALL be a power of two, at least 2.
REQ-002 Parameter LOAD_CYCLES, default 2, is the number of cycles mul_rst is held high per job to load operands.
REQ-003 Parameter MUL_LATENCY, default 33, is the cycles from mul_rst falling until mul_out is valid.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 op_valid  in  1  upstream operand pair valid.
REQ-007 op_ready  out  1  queue can accept a pair this cycle.
REQ-008 op_a, op_b  in  32 each  signed operands.
REQ-009 mul_rst  out  1  active-high load/restart strobe to the multiplier.
REQ-010 mul_in1, mul_in2  out  32 each  registered operands to the multiplier.
REQ-011 mul_out  in  64  multiplier product.
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  downstream accepts the result.
REQ-014 res_data  out  64  signed product.
REQ-015 busy  out  1  high in any state other than IDLE, or when the queue is non-empty.

Function
REQ-016 Push SHALL occur when op_valid && op_ready; op_ready SHALL equal !full, registered, with no same-cycle pass-through when full.
REQ-017 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-018 IDLE -> LOAD on the cycle after the queue is non-empty: pop the head, register it to mul_in1/mul_in2, set mul_rst=1.
REQ-019 LOAD SHALL last exactly LOAD_CYCLES cycles, then deassert mul_rst and enter RUN.
REQ-020 RUN SHALL count MUL_LATENCY cycles, then capture mul_out into res_data, set res_valid=1 and enter DONE.
REQ-021 mul_in1/mul_in2 SHALL remain stable from LOAD through DONE.
REQ-022 DONE -> IDLE on res_valid && res_ready, which clears res_valid; res_data SHALL hold until then.
REQ-023 The queue SHALL keep accepting pushes during LOAD, RUN and DONE; results SHALL be returned in push order.
REQ-024 Latency: a pair pushed at edge t into an empty queue with the FSM in IDLE SHALL produce res_valid at edge t+1+LOAD_CYCLES+MUL_LATENCY (t+36 with defaults).
REQ-025 Push on the same cycle as pop SHALL be accepted when not full, and occupancy SHALL be unchanged.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-027 Outside LOAD, mul_rst SHALL be 0, except during reset.

Reset
REQ-028 On rst=0 the block SHALL asynchronously clear the queue, pointers and counter and enter IDLE.
REQ-029 During reset, outputs SHALL be op_ready=0, mul_rst=1, mul_in1=mul_in2=0, res_valid=0, res_data=0 and busy=0.
REQ-030 Reset mid-job SHALL abort the job and discard it and all queued pairs; no result SHALL be emitted for them.
REQ-031 op_ready SHALL rise on the first edge after rst returns to 1.

Configuration
REQ-032 The feature SHALL be selected by macro MULT_SEQ_ZERO_BYPASS_EN.
REQ-033 With the macro defined, a popped pair with op_a==0 or op_b==0 SHALL skip LOAD/RUN and go directly to DONE with res_data=0 one edge after the pop; mul_rst SHALL stay 0 for that job.
REQ-034 With the macro undefined, every pair SHALL take the full LOAD/RUN path.

Verification
REQ-035 Push (2,5) into an idle block -> res_valid at t+36, res_data=10.
REQ-036 Push (2,-5), (-132,-5) and (-132,5) back-to-back with res_ready=1 -> results in order: 0xFFFFFFFFFFFFFFF6, 660, 0xFFFFFFFFFFFFFD6C.
REQ-037 Push 5 pairs with res_ready=0 -> op_ready=0 after the queue holds 4 pairs plus 1 in service; the first result holds stable until res_ready rises; all 5 results are returned correctly.
REQ-038 Push (2147483647,2147483647) then (-1,-1) -> results 4611686014132420609 and 1.
REQ-039 Assert rst=0 during RUN with 2 pairs queued -> immediate reset values on outputs; no res_valid ever for the aborted pairs; (5,1) pushed afterwards returns 5.
REQ-040 With MULT_SEQ_ZERO_BYPASS_EN defined, push (5,0) -> res_data=0 two edges after the push and mul_rst never pulses; with the macro undefined, res_data=0 at t+36.
